// File: rtl/iic_m_reg_access.sv
// Single-byte IIC register read/write sequencer feeding the IIC master PHY user channels.
// Define IIC_M_REG_ADDR16_EN to send a 16-bit register address (adds the REG_H byte).
module iic_m_reg_access #(
    parameter int U_DLY  = 1,
    parameter int RD_TMO = 65535
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rdwrn,
    input  logic [6:0]  req_dev,
    input  logic [15:0] req_reg,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        phy_wready,
    output logic        phy_wvalid,
    output logic [3:0]  phy_wcmd,
    output logic [7:0]  phy_wdata,
    input  logic [7:0]  phy_rdata,
    input  logic        phy_rvalid,
    input  logic        phy_err_sack
);
    localparam logic [15:0] TMO_LIMIT    = 16'(RD_TMO);
    localparam int          u_dly_unused = U_DLY;

    typedef enum logic [3:0] {
        IDLE,
        DEV_W,
`ifdef IIC_M_REG_ADDR16_EN
        REG_H,
`endif
        REG_L,
        WDATA,
        DEV_R,
        RDATA,
        WAIT_RD,
        DONE
    } state_t;

    state_t      state;
    logic        rdwrn_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_lo_q;
    logic [7:0]  wdata_q;
    logic        err_flag;
    logic [15:0] tmo_cnt;

`ifdef IIC_M_REG_ADDR16_EN
    logic [7:0]  reg_hi_q;
`else
    logic        unused_reg_hi;
    assign unused_reg_hi = ^req_reg[15:8];
`endif

    // Outputs are registered alongside the state: each transition loads the
    // command/data pair of the state being entered, so bytes follow without bubbles.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            phy_wvalid <= 1'b0;
            phy_wcmd   <= 4'b0000;
            phy_wdata  <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'h00;
            rsp_err    <= 1'b0;
            rdwrn_q    <= 1'b0;
            dev_q      <= 7'h00;
            reg_lo_q   <= 8'h00;
`ifdef IIC_M_REG_ADDR16_EN
            reg_hi_q   <= 8'h00;
`endif
            wdata_q    <= 8'h00;
            err_flag   <= 1'b0;
            tmo_cnt    <= 16'h0000;
        end else begin
            rsp_valid <= 1'b0;
            // Slave NACK is sticky for the whole transaction; the sequence still runs to completion.
            if (state != IDLE && phy_err_sack) begin
                err_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rdwrn_q    <= req_rdwrn;
                        dev_q      <= req_dev;
                        reg_lo_q   <= req_reg[7:0];
`ifdef IIC_M_REG_ADDR16_EN
                        reg_hi_q   <= req_reg[15:8];
`endif
                        wdata_q    <= req_wdata;
                        err_flag   <= 1'b0;
                        req_ready  <= 1'b0;
                        phy_wvalid <= 1'b1;
                        phy_wcmd   <= 4'b0001;
                        phy_wdata  <= {req_dev, 1'b0};
                        state      <= DEV_W;
                    end
                end
                DEV_W: begin
                    if (phy_wready) begin
                        phy_wcmd  <= 4'b0000;
`ifdef IIC_M_REG_ADDR16_EN
                        phy_wdata <= reg_hi_q;
                        state     <= REG_H;
`else
                        phy_wdata <= reg_lo_q;
                        state     <= REG_L;
`endif
                    end
                end
`ifdef IIC_M_REG_ADDR16_EN
                REG_H: begin
                    if (phy_wready) begin
                        phy_wcmd  <= 4'b0000;
                        phy_wdata <= reg_lo_q;
                        state     <= REG_L;
                    end
                end
`endif
                REG_L: begin
                    if (phy_wready) begin
                        if (rdwrn_q) begin
                            phy_wcmd  <= 4'b0001;
                            phy_wdata <= {dev_q, 1'b1};
                            state     <= DEV_R;
                        end else begin
                            phy_wcmd  <= 4'b0010;
                            phy_wdata <= wdata_q;
                            state     <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (phy_wready) begin
                        phy_wvalid <= 1'b0;
                        phy_wcmd   <= 4'b0000;
                        phy_wdata  <= 8'h00;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= 8'h00;
                        rsp_err    <= err_flag | phy_err_sack;
                        state      <= DONE;
                    end
                end
                DEV_R: begin
                    if (phy_wready) begin
                        phy_wcmd  <= 4'b1110;
                        phy_wdata <= 8'h00;
                        state     <= RDATA;
                    end
                end
                RDATA: begin
                    if (phy_wready) begin
                        phy_wvalid <= 1'b0;
                        phy_wcmd   <= 4'b0000;
                        phy_wdata  <= 8'h00;
                        tmo_cnt    <= 16'h0000;
                        state      <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (phy_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= phy_rdata;
                        rsp_err   <= err_flag | phy_err_sack;
                        state     <= DONE;
                    end else if (tmo_cnt == TMO_LIMIT) begin
                        err_flag  <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 8'h00;
                        rsp_err   <= 1'b1;
                        state     <= DONE;
                    end else if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    phy_wvalid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_m_reg_access.sv
// Self-checking bench for iic_m_reg_access: table vectors, randomized transactions and reset corner cases.
// Byte streams and responses are predicted at transaction level from the request fields.
module tb_iic_m_reg_access;
    localparam int TB_RD_TMO = 16;
`ifdef IIC_M_REG_ADDR16_EN
    localparam int REG_L_IDX = 2;
`else
    localparam int REG_L_IDX = 1;
`endif
    localparam int DEV_R_IDX = REG_L_IDX + 1;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rdwrn = 1'b0;
    logic [6:0]  req_dev = 7'h00;
    logic [15:0] req_reg = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        phy_wready = 1'b0;
    logic        phy_wvalid;
    logic [3:0]  phy_wcmd;
    logic [7:0]  phy_wdata;
    logic [7:0]  phy_rdata = 8'h00;
    logic        phy_rvalid = 1'b0;
    logic        phy_err_sack = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];

    typedef struct {
        logic        rdwrn;
        logic [6:0]  dev;
        logic [15:0] regaddr;
        logic [7:0]  wdata;
        logic [7:0]  rbyte;
        int          sack_byte;
        int          stall;
        int          rd_delay;
        logic        tmo;
        logic [7:0]  exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    iic_m_reg_access #(.U_DLY(1), .RD_TMO(TB_RD_TMO)) dut (
        .clk_sys(clk_sys),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rdwrn(req_rdwrn),
        .req_dev(req_dev),
        .req_reg(req_reg),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .phy_wready(phy_wready),
        .phy_wvalid(phy_wvalid),
        .phy_wcmd(phy_wcmd),
        .phy_wdata(phy_wdata),
        .phy_rdata(phy_rdata),
        .phy_rvalid(phy_rvalid),
        .phy_err_sack(phy_err_sack)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected PHY byte stream derived directly from the request.
    task automatic build_expected(input logic rdwrn, input logic [6:0] dev,
                                  input logic [15:0] regaddr, input logic [7:0] wdata);
        exp_q.delete();
        exp_q.push_back({4'b0001, dev, 1'b0});
`ifdef IIC_M_REG_ADDR16_EN
        exp_q.push_back({4'b0000, regaddr[15:8]});
`endif
        exp_q.push_back({4'b0000, regaddr[7:0]});
        if (rdwrn) begin
            exp_q.push_back({4'b0001, dev, 1'b1});
            exp_q.push_back({4'b1110, 8'h00});
        end else begin
            exp_q.push_back({4'b0010, wdata});
        end
    endtask

    function automatic int n_bytes(input logic rdwrn);
        return (rdwrn ? 4 : 3) + REG_L_IDX - 1;
    endfunction

    // Runs one transaction from an idle DUT; returns at posedge+1 with the DUT idle again.
    task automatic applyStimulus(input vec_t v, input int bp_pct);
        int          n_exp, hs_cnt, last_hs, rv_cyc, rsp_cyc, stall_cnt, exp_cyc;
        bit          holding, sack_done, got_rsp;
        logic [11:0] held;
        logic [7:0]  rdata_s;
        logic        err_s;
        build_expected(v.rdwrn, v.dev, v.regaddr, v.wdata);
        n_exp = exp_q.size();
        obs_q.delete();
        hs_cnt = 0; last_hs = -1; rv_cyc = -1; rsp_cyc = -1; stall_cnt = 0;
        holding = 0; sack_done = 0; got_rsp = 0; held = '0; rdata_s = '0; err_s = 1'b0;
        req_valid = 1'b1; req_rdwrn = v.rdwrn; req_dev = v.dev; req_reg = v.regaddr;
        req_wdata = v.wdata; phy_err_sack = 1'b1; phy_wready = 1'b0; phy_rvalid = 1'b0;
        @(posedge clk_sys); #1;
        req_valid = 1'b0; req_rdwrn = ~v.rdwrn; req_dev = 7'($urandom);
        req_reg = 16'($urandom); req_wdata = 8'($urandom);
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        checkOutput("wvalid_T1", 32'(phy_wvalid), 32'd1);
        for (int cyc = 1; cyc < 3000 && !got_rsp; cyc++) begin
            if (cyc > 1) begin @(posedge clk_sys); #1; end
            phy_wready = 1'b0; phy_rvalid = 1'b0; phy_err_sack = 1'b0; phy_rdata = 8'($urandom);
            if (rsp_valid) begin
                got_rsp = 1; rsp_cyc = cyc; rdata_s = rsp_rdata; err_s = rsp_err;
                phy_err_sack = 1'b1;
            end else if (hs_cnt < n_exp) begin
                checkOutput("wvalid_no_bubble", 32'(phy_wvalid), 32'd1);
                if (holding) checkOutput("held_cmd_data", 32'({phy_wcmd, phy_wdata}), 32'(held));
                if (v.sack_byte == hs_cnt && !sack_done) begin
                    phy_err_sack = 1'b1; sack_done = 1;
                end
                phy_rvalid = ($urandom_range(3) == 0);
                if (v.stall > 0) phy_wready = (stall_cnt == v.stall);
                else phy_wready = ($urandom_range(99) >= bp_pct);
                if (phy_wready) begin
                    obs_q.push_back({phy_wcmd, phy_wdata});
                    hs_cnt++; holding = 0; last_hs = cyc; stall_cnt = 0;
                end else begin
                    holding = 1; held = {phy_wcmd, phy_wdata}; stall_cnt++;
                end
            end else begin
                checkOutput("wvalid_low_wait", 32'(phy_wvalid), 32'd0);
                if (v.rdwrn && !v.tmo && cyc == last_hs + 1 + v.rd_delay) begin
                    phy_rvalid = 1'b1; phy_rdata = v.rbyte; rv_cyc = cyc;
                end
            end
        end
        if (!got_rsp) begin
            checkOutput("rsp_missing", 32'd0, 32'd1);
        end else begin
            if (!v.rdwrn) exp_cyc = last_hs + 1;
            else if (v.tmo) exp_cyc = last_hs + TB_RD_TMO + 2;
            else exp_cyc = rv_cyc + 1;
            checkOutput("rsp_cycle", 32'(rsp_cyc), 32'(exp_cyc));
            checkOutput("rsp_rdata", 32'(rdata_s), 32'(v.exp_rdata));
            checkOutput("rsp_err", 32'(err_s), 32'(v.exp_err));
        end
        checkOutput("byte_count", 32'(obs_q.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < obs_q.size(); i++)
            checkOutput($sformatf("byte_%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
        @(posedge clk_sys); #1;
        phy_err_sack = 1'b0;
        checkOutput("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        checkOutput("rdata_hold", 32'(rsp_rdata), 32'(v.exp_rdata));
        checkOutput("err_hold", 32'(rsp_err), 32'(v.exp_err));
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_wvalid"}, 32'(phy_wvalid), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        checkOutput({tag, "_wcmd"}, 32'(phy_wcmd), 32'd0);
        checkOutput({tag, "_wdata"}, 32'(phy_wdata), 32'd0);
        checkOutput({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
    endtask

    // Reset while DEV_R is presented with a pending (unaccepted) handshake.
    task automatic reset_mid_read();
        bit found;
        bit saw_rsp;
        found = 0; saw_rsp = 0;
        req_valid = 1'b1; req_rdwrn = 1'b1; req_dev = 7'h33; req_reg = 16'h0044;
        @(posedge clk_sys); #1;
        req_valid = 1'b0; phy_wready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (phy_wvalid && phy_wcmd == 4'b0001 && phy_wdata == 8'h67) begin
                found = 1; phy_wready = 1'b0; rst = 1'b1;
            end else begin
                @(posedge clk_sys); #1;
            end
        end
        checkOutput("rst_reached_dev_r", 32'(found), 32'd1);
        @(posedge clk_sys); #1;
        rst = 1'b0;
        check_reset_values("mid_rst");
        for (int i = 0; i < 25; i++) begin
            phy_rvalid = (i % 3 == 0); phy_rdata = 8'h5E;
            @(posedge clk_sys); #1;
            if (rsp_valid) saw_rsp = 1;
        end
        phy_rvalid = 1'b0;
        checkOutput("no_rsp_after_rst", 32'(saw_rsp), 32'd0);
        checkOutput("idle_after_rst", 32'(req_ready), 32'd1);
    endtask

    initial begin
        vec_t rv;
        //           rdwrn dev    reg       wdata  rbyte  sack       stall dly tmo   exp_rd exp_err
        vecs[0] = '{1'b0, 7'h50, 16'h0012, 8'hA5, 8'h00, -1,         0,    0,  1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 7'h50, 16'h0012, 8'h00, 8'h3C, -1,         0,    3,  1'b0, 8'h3C, 1'b0};
        vecs[2] = '{1'b0, 7'h2A, 16'h0077, 8'h5A, 8'h00, -1,         10,   0,  1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 7'h11, 16'h00C4, 8'h99, 8'h00, REG_L_IDX,  0,    0,  1'b0, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 7'h11, 16'h00C5, 8'h98, 8'h00, -1,         0,    0,  1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 7'h48, 16'h0003, 8'h00, 8'hAA, -1,         0,    0,  1'b1, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 7'h50, 16'h1234, 8'h7E, 8'h00, -1,         0,    0,  1'b0, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 7'h00, 16'hFFFF, 8'h00, 8'h00, -1,         2,    0,  1'b0, 8'h00, 1'b0};
        vecs[8] = '{1'b1, 7'h7F, 16'h0081, 8'h00, 8'hC3, DEV_R_IDX,  0,    7,  1'b0, 8'hC3, 1'b1};

        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_values("in_rst");
        rst = 1'b0;
        @(posedge clk_sys); #1;
        check_reset_values("post_rst");

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], 0);

        reset_mid_read();

        for (int i = 0; i < 40; i++) begin
            rv.rdwrn     = 1'($urandom);
            rv.dev       = 7'($urandom);
            rv.regaddr   = 16'($urandom);
            rv.wdata     = 8'($urandom);
            rv.rbyte     = 8'($urandom);
            rv.sack_byte = int'($urandom_range(9)) - 4;
            rv.stall     = 0;
            rv.rd_delay  = int'($urandom_range(TB_RD_TMO - 1));
            rv.tmo       = rv.rdwrn && ($urandom_range(7) == 0);
            rv.exp_rdata = (rv.rdwrn && !rv.tmo) ? rv.rbyte : 8'h00;
            rv.exp_err   = rv.tmo || (rv.sack_byte >= 0 && rv.sack_byte < n_bytes(rv.rdwrn));
            applyStimulus(rv, int'($urandom_range(60)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iic_m_reg_access.md
# iic_m_reg_access

Register-access sequencer that sits directly upstream of the IIC master PHY. It accepts one single-byte register read or write request, emits the matching byte/command stream on the PHY user write channel, collects the read byte from the PHY user read channel, and returns one response per request. A read uses a repeated-START sequence.

## Interface
Parameters:
- U_DLY, 1: simulation register delay on sequential assignments.
- RD_TMO, 65535: maximum cycles to wait for a read byte before timing out. Range 1..65535.

Ports:
- clk_sys  in  1  system clock. One clock, reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready. High only in IDLE.
- req_rdwrn  in  1  1 = read, 0 = write.
- req_dev  in  7  7-bit device address.
- req_reg  in  16  register address. Bits [15:8] are used only with IIC_M_REG_ADDR16_EN.
- req_wdata  in  8  write data. Ignored for reads.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  8  read data. 0x00 for writes and on timeout.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- phy_wready  in  1  PHY accepts the command byte.
- phy_wvalid  out  1  command byte valid.
- phy_wcmd  out  4  PHY command. bit3 = master ack value (1 = NACK), bit2 = rd/wrn, bit1 = end (STOP), bit0 = start.
- phy_wdata  out  8  byte to transmit.
- phy_rdata  in  8  received byte.
- phy_rvalid  in  1  received byte strobe.
- phy_err_sack  in  1  slave-NACK error indication from the PHY.

## Operation
- States: IDLE, DEV_W, REG_H (only with the macro), REG_L, WDATA, DEV_R, RDATA, WAIT_RD, DONE.
- IDLE: on req_valid & req_ready, latch all req_* fields, clear the internal error flag, and go to DEV_W.
- Each command state drives phy_wvalid = 1 with a fixed {phy_wcmd, phy_wdata} pair.
  - DEV_W: {0001, {dev,0}}
  - REG_H: {0000, reg[15:8]}
  - REG_L: {0000, reg[7:0]}
  - WDATA: {0010, wdata}
  - DEV_R: {0001, {dev,1}}
  - RDATA: {1110, 0x00}
- Transitions occur only on phy_wvalid & phy_wready.
  - Write path: DEV_W → [REG_H] → REG_L → WDATA → DONE.
  - Read path: DEV_W → [REG_H] → REG_L → DEV_R → RDATA → WAIT_RD.
- WAIT_RD: phy_rvalid captures phy_rdata and moves to DONE. The timeout counter reaching RD_TMO sets the error flag, forces rdata to 0x00, and moves to DONE.
- DONE: rsp_valid = 1 for exactly one cycle, then return to IDLE.
- phy_err_sack sampled high in any non-IDLE state sets a sticky error flag. The sequence is not aborted. The flag is reported on rsp_err.
- The timeout counter is 16 bits, cleared on entry to WAIT_RD, and saturates; it never wraps.

## Timing
- Reset values:
  - req_ready = 1 (IDLE).
  - phy_wvalid, rsp_valid, rsp_err = 0.
  - phy_wcmd = 0000.
  - phy_wdata, rsp_rdata = 0x00.
- Request accepted at cycle T: phy_wvalid = 1 from T+1.
- Back-to-back bytes: the next byte is valid in the cycle after a handshake. phy_wvalid stays high with no bubble between bytes of one transaction.
- phy_wcmd and phy_wdata are held stable while phy_wvalid & !phy_wready.
- Write: final handshake at cycle H gives rsp_valid at H+1.
- Read: phy_rvalid at cycle R gives rsp_valid at R+1 with rsp_rdata = the captured byte.
- phy_rvalid is ignored in every state except WAIT_RD, including the RDATA handshake cycle.
- Timeout: rsp_valid occurs RD_TMO+1 cycles after WAIT_RD entry.
- phy_err_sack coincident with the DONE→IDLE transition is ignored.
- rst asserted mid-transaction:
  - Next cycle all outputs take their reset values.
  - No response is issued.
  - phy_wvalid drops even if the handshake is pending.
- rsp_rdata and rsp_err hold their values until the next DONE.

## Configuration
- IIC_M_REG_ADDR16_EN defined: the REG_H state is present, sending req_reg[15:8] before req_reg[7:0].
- Undefined: the REG_H state and its logic are removed; req_reg[15:8] is ignored. Each sequence is one byte shorter.

## Test plan
- Write, dev 0x50, reg 0x12, data 0xA5, phy_wready tied high → bytes (0001,0xA0), (0000,0x12), (0010,0xA5) on consecutive cycles. rsp_valid one cycle later, rsp_err = 0, rsp_rdata = 0x00.
- Read, dev 0x50, reg 0x12 → bytes (0001,0xA0), (0000,0x12), (0001,0xA1), (1110,0x00). Then phy_rvalid with 0x3C → rsp_rdata = 0x3C, rsp_err = 0.
- Backpressure: phy_wready low for 10 cycles on each byte → phy_wvalid held high with cmd/data stable throughout. Byte order is unchanged.
- phy_err_sack pulsed during REG_L of a write → all three bytes still sent, rsp_err = 1. The next clean request reports rsp_err = 0.
- RD_TMO = 16, read with no phy_rvalid → rsp_valid exactly 17 cycles after WAIT_RD entry, rsp_err = 1, rsp_rdata = 0x00.
- With the macro, write to reg 0x1234 → bytes 0xA0, 0x12, 0x34, then data. Separately, rst during DEV_R → phy_wvalid = 0 next cycle, no rsp_valid, req_ready = 1.
